// File: rtl/acc_bank_pkg.sv
// Shared constants and helpers for the multi-channel saturating accumulator bank.
// Width-generic values are returned in 64 bits; callers cast them down to their own width.
package acc_bank_pkg;

  function automatic int ch_bits(input int n);
    int r;
    if (n <= 1) begin
      r = 1;
    end else begin
      r = $clog2(n);
    end
    return r;
  endfunction

  // Largest signed value of width w: bits below w-1 set, everything above clear.
  function automatic logic [63:0] sat_max(input int w);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < w - 1) begin
        r[i] = 1'b1;
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  function automatic logic [63:0] sign_ext(input logic [63:0] v, input int w);
    logic [63:0] r;
    logic        msb;
    msb = 1'b0;
    r   = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i == w - 1) begin
        msb = v[i];
      end else begin
        msb = msb;
      end
    end
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        r[i] = v[i];
      end else begin
        r[i] = msb;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_bank_if.sv
// Sample-in / result-out handshake bundle of the accumulator bank.
// The bank connects through the slave modport; a producer/consumer uses master.
interface acc_bank_if
  import acc_bank_pkg::*;
#(
  parameter int IN_WIDTH  = 14,
  parameter int ACC_WIDTH = 18,
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = ch_bits(CHANNELS)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CH_BITS-1:0]   in_ch;
  logic                 in_load;
  logic                 in_add;
  logic                 in_last;
  logic [ACC_WIDTH-1:0] in_init;
  logic [IN_WIDTH-1:0]  in_a;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH_BITS-1:0]   out_ch;
  logic [ACC_WIDTH-1:0] out_y;
  logic                 out_overflow;

  modport master (
    output in_valid, in_ch, in_load, in_add, in_last, in_init, in_a, out_ready,
    input  in_ready, out_valid, out_ch, out_y, out_overflow
  );

  modport slave (
    input  in_valid, in_ch, in_load, in_add, in_last, in_init, in_a, out_ready,
    output in_ready, out_valid, out_ch, out_y, out_overflow
  );
endinterface

// File: rtl/acc_bank_sat_adder.sv
// Signed WIDTH-bit adder with overflow detect; clamps to min/max when SATURATE is set,
// otherwise wraps. This is the only arithmetic in the bank.
module sat_adder
  import acc_bank_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter bit SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             v
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] sum_s;

  assign sum_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign v     = sum_s[WIDTH] ^ sum_s[WIDTH-1];

  // Clamp toward the sign of the true (WIDTH+1)-bit sum.
  always_comb begin
    y = sum_s[WIDTH-1:0];
    if (v && SATURATE) begin
      if (sum_s[WIDTH]) begin
        y = MIN_V;
      end else begin
        y = MAX_V;
      end
    end else begin
      y = sum_s[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/acc_bank.sv
// Multi-channel signed accumulator bank: one running sum and sticky overflow per channel,
// one beat per cycle, and a registered result emitted when a beat closes a channel's window.
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int IN_WIDTH  = 14,
  parameter int ACC_WIDTH = 18,
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = ch_bits(CHANNELS),
  parameter bit SATURATE  = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  acc_bank_if.slave bus
);
  localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS+1)'(CHANNELS);

  logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_d [CHANNELS];
  logic [CHANNELS-1:0]  sticky_q, sticky_d;
  logic                 out_valid_q, out_valid_d;
  logic [CH_BITS-1:0]   out_ch_q, out_ch_d;
  logic [ACC_WIDTH-1:0] out_y_q, out_y_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 in_ready_s, accept_s, ch_ok_s, take_s;
  logic [ACC_WIDTH-1:0] acc_rd_s, left_s, right_s, result_s;
  logic                 sticky_rd_s, ovf_s;

  assign in_ready_s = !flush && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign ch_ok_s    = {1'b0, bus.in_ch} < CH_LIMIT;
  assign take_s     = accept_s && ch_ok_s;

  // Read port of the channel file; an out-of-range index reads zero and is never written.
  always_comb begin
    acc_rd_s    = '0;
    sticky_rd_s = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CH_BITS'(c) == bus.in_ch) begin
        acc_rd_s    = acc_q[c];
        sticky_rd_s = sticky_q[c];
      end else begin
        acc_rd_s    = acc_rd_s;
        sticky_rd_s = sticky_rd_s;
      end
    end
  end

  assign left_s  = bus.in_load ? bus.in_init : acc_rd_s;
  assign right_s = bus.in_add ? ACC_WIDTH'(sign_ext(64'(bus.in_a), IN_WIDTH)) : '0;

  sat_adder #(
    .WIDTH    (ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .a (left_s),
    .b (right_s),
    .y (result_s),
    .v (ovf_s)
  );

  // Channel file next state: flush clears everything, a closing beat clears its channel.
  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = '0;
      end
      sticky_d = '0;
    end else if (take_s) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (CH_BITS'(c) == bus.in_ch) begin
          if (bus.in_last) begin
            acc_d[c]    = '0;
            sticky_d[c] = 1'b0;
          end else begin
            acc_d[c]    = result_s;
            sticky_d[c] = sticky_q[c] | ovf_s;
          end
        end else begin
          acc_d[c] = acc_q[c];
        end
      end
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Output register: a closing beat replaces the held result even while it drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_y_d     = out_y_q;
    out_ovf_d   = out_ovf_q;
    if (take_s && bus.in_last) begin
      out_valid_d = 1'b1;
      out_ch_d    = bus.in_ch;
      out_y_d     = result_s;
      out_ovf_d   = sticky_rd_s | ovf_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Channel file state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
      sticky_q <= '0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_y_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_y_q     <= out_y_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_ch       = out_ch_q;
  assign bus.out_y        = out_y_q;
  assign bus.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_acc_bank.sv
// Drives a saturating 4-channel bank and a wrapping 3-channel bank with identical beats
// and checks both against an integer reference model plus a table of hand-derived results.
module tb_acc_bank;
  localparam longint MAXV = 131071;
  localparam longint MINV = -131072;
  localparam longint SPAN = 262144;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  acc_bank_if #(.IN_WIDTH(14), .ACC_WIDTH(18), .CHANNELS(4)) bus0 ();
  acc_bank_if #(.IN_WIDTH(14), .ACC_WIDTH(18), .CHANNELS(3)) bus1 ();

  acc_bank #(.IN_WIDTH(14), .ACC_WIDTH(18), .CHANNELS(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus0)
  );
  acc_bank #(.IN_WIDTH(14), .ACC_WIDTH(18), .CHANNELS(3), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per bank, plain integer sums and the pending result.
  longint m_acc [2][4];
  bit     m_st  [2][4];
  bit     m_ov  [2];
  int     m_och [2];
  longint m_oy  [2];
  bit     m_oo  [2];
  int     nch   [2] = '{4, 3};
  bit     satm  [2] = '{1'b1, 1'b0};

  typedef struct {
    bit v; int ch; bit ld; bit ad; bit la; int init; int a;
    bit ev; int ech; int ey; bit eo;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        m_acc[d][c] = 0;
        m_st[d][c]  = 1'b0;
      end
      m_ov[d] = 1'b0; m_och[d] = 0; m_oy[d] = 0; m_oo[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit v, input int ch, input bit ld, input bit ad, input bit la,
                            input int init, input int a, input bit ordy, input bit fl);
    for (int d = 0; d < 2; d++) begin
      bit rdy, ok, ovf;
      longint l, s, res;
      rdy = !fl && (!m_ov[d] || ordy);
      ok  = v && rdy && (ch < nch[d]);
      if (fl) begin
        for (int c = 0; c < 4; c++) begin
          m_acc[d][c] = 0;
          m_st[d][c]  = 1'b0;
        end
      end else if (ok) begin
        l   = ld ? longint'(init) : m_acc[d][ch];
        s   = l + (ad ? longint'(a) : 0);
        ovf = (s > MAXV) || (s < MINV);
        if (!ovf) res = s;
        else if (satm[d]) res = (s > MAXV) ? MAXV : MINV;
        else res = (s > MAXV) ? s - SPAN : s + SPAN;
        if (la) begin
          m_oy[d] = res; m_och[d] = ch; m_oo[d] = m_st[d][ch] | ovf; m_ov[d] = 1'b1;
          m_acc[d][ch] = 0; m_st[d][ch] = 1'b0;
        end else begin
          m_acc[d][ch] = res; m_st[d][ch] = m_st[d][ch] | ovf;
        end
      end
      if (!(ok && la) && ordy) m_ov[d] = 1'b0;
    end
  endtask

  task automatic drive(input bit v, input int ch, input bit ld, input bit ad, input bit la,
                       input int init, input int a, input bit ordy, input bit fl);
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.in_ch = ch[1:0]; bus1.in_ch = ch[1:0];
    bus0.in_load = ld;  bus1.in_load = ld;
    bus0.in_add = ad;   bus1.in_add = ad;
    bus0.in_last = la;  bus1.in_last = la;
    bus0.in_init = init[17:0]; bus1.in_init = init[17:0];
    bus0.in_a = a[13:0]; bus1.in_a = a[13:0];
    bus0.out_ready = ordy; bus1.out_ready = ordy;
    flush = fl;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " valid0"}, bus0.out_valid, m_ov[0]);
    chk({tag, " valid1"}, bus1.out_valid, m_ov[1]);
    if (m_ov[0]) begin
      chk({tag, " ch0"}, bus0.out_ch, m_och[0]);
      chk({tag, " y0"}, $signed(bus0.out_y), m_oy[0]);
      chk({tag, " ovf0"}, bus0.out_overflow, m_oo[0]);
    end
    if (m_ov[1]) begin
      chk({tag, " ch1"}, bus1.out_ch, m_och[1]);
      chk({tag, " y1"}, $signed(bus1.out_y), m_oy[1]);
      chk({tag, " ovf1"}, bus1.out_overflow, m_oo[1]);
    end
  endtask

  // One beat: starts just after a rising edge, ends just after the next one.
  task automatic step(input string tag, input bit v, input int ch, input bit ld, input bit ad,
                      input bit la, input int init, input int a, input bit ordy, input bit fl);
    drive(v, ch, ld, ad, la, init, a, ordy, fl);
    @(negedge clk);
    chk({tag, " ready0"}, bus0.in_ready, !fl && (!m_ov[0] || ordy));
    chk({tag, " ready1"}, bus1.in_ready, !fl && (!m_ov[1] || ordy));
    @(posedge clk);
    model_edge(v, ch, ld, ad, la, init, a, ordy, fl);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " valid0"}, bus0.out_valid, 0);
    chk({tag, " ch0"}, bus0.out_ch, 0);
    chk({tag, " y0"}, bus0.out_y, 0);
    chk({tag, " ovf0"}, bus0.out_overflow, 0);
    chk({tag, " valid1"}, bus1.out_valid, 0);
    chk({tag, " y1"}, bus1.out_y, 0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    model_reset();
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset ready", bus0.in_ready, 1);

    // basic accumulate, readback of a cleared channel, interleaved channels,
    // positive saturation and sticky overflow
    vt.push_back('{1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 5, 1'b0, 0, 0, 1'b0});
    vt.push_back('{1'b1, 0, 1'b0, 1'b1, 1'b0, 0, 7, 1'b0, 0, 0, 1'b0});
    vt.push_back('{1'b1, 0, 1'b0, 1'b1, 1'b1, 0, -3, 1'b1, 0, 9, 1'b0});
    vt.push_back('{1'b1, 0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 0, 0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      vt.push_back('{1'b1, 1, 1'b0, 1'b1, 1'b0, 0, 100, 1'b0, 0, 0, 1'b0});
      vt.push_back('{1'b1, 2, 1'b0, 1'b1, 1'b0, 0, -50, 1'b0, 0, 0, 1'b0});
    end
    vt.push_back('{1'b1, 1, 1'b0, 1'b1, 1'b1, 0, 100, 1'b1, 1, 400, 1'b0});
    vt.push_back('{1'b1, 2, 1'b0, 1'b1, 1'b1, 0, -50, 1'b1, 2, -200, 1'b0});
    vt.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 131000, 8191, 1'b0, 0, 0, 1'b0});
    vt.push_back('{1'b1, 1, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 1, 131071, 1'b1});
    vt.push_back('{1'b1, 0, 1'b1, 1'b1, 1'b0, 131000, 8191, 1'b0, 0, 0, 1'b0});
    vt.push_back('{1'b1, 0, 1'b0, 1'b1, 1'b1, 0, -8192, 1'b1, 0, 122879, 1'b1});
    vt.push_back('{1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 10, 1'b0, 0, 0, 1'b0});
    vt.push_back('{1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 5, 1'b1, 0, 15, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      string tg;
      tg = $sformatf("vec%0d", i);
      step(tg, vt[i].v, vt[i].ch, vt[i].ld, vt[i].ad, vt[i].la, vt[i].init, vt[i].a, 1'b1, 1'b0);
      chk({tg, " tbl valid"}, bus0.out_valid, vt[i].ev);
      if (vt[i].ev) begin
        chk({tg, " tbl ch"}, bus0.out_ch, vt[i].ech);
        chk({tg, " tbl y"}, $signed(bus0.out_y), vt[i].ey);
        chk({tg, " tbl ovf"}, bus0.out_overflow, vt[i].eo);
      end
    end

    // backpressure: result held, input blocked, then drain and refill with no bubble
    step("bp fill", 1'b1, 2, 1'b0, 1'b1, 1'b1, 0, 20, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step("bp hold", 1'b1, 2, 1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
      chk("bp hold y", $signed(bus0.out_y), 20);
      chk("bp hold ready", bus0.in_ready, 0);
    end
    step("bp drain", 1'b1, 2, 1'b0, 1'b1, 1'b1, 0, 7, 1'b1, 1'b0);
    chk("bp drain valid", bus0.out_valid, 1);
    chk("bp drain y", $signed(bus0.out_y), 7);

    // flush clears sums but leaves the pending result; ch3 is out of range for the 3-channel bank
    step("fl load", 1'b1, 1, 1'b1, 1'b0, 1'b0, 500, 0, 1'b1, 1'b0);
    step("fl ch3", 1'b1, 3, 1'b0, 1'b1, 1'b1, 0, 9, 1'b1, 1'b0);
    step("fl flush", 1'b1, 1, 1'b0, 1'b1, 1'b1, 0, 3, 1'b0, 1'b1);
    chk("fl held y", $signed(bus0.out_y), 9);
    chk("fl held ch", bus0.out_ch, 3);
    step("fl read", 1'b1, 1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
    chk("fl read y", $signed(bus0.out_y), 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [17:0] r18;
      logic [13:0] r14;
      int init, a, sel;
      r18 = 18'($urandom);
      r14 = 14'($urandom);
      sel = int'($urandom_range(0, 2));
      if (sel == 0) init = int'($signed(r18));
      else if (sel == 1) init = 131071 - int'($urandom_range(0, 2000));
      else init = -131072 + int'($urandom_range(0, 2000));
      a = int'($signed(r14));
      step("rnd", $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, init, a,
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

    // asynchronous reset in the middle of a window with a result pending
    step("rs part", 1'b1, 2, 1'b0, 1'b1, 1'b0, 0, 100, 1'b1, 1'b0);
    step("rs last", 1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 5, 1'b1, 1'b0);
    step("rs idle", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("async rst");
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    step("rs ch3", 1'b1, 3, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
    chk("rs ch3 valid", bus0.out_valid, 1);
    chk("rs ch3 ch", bus0.out_ch, 3);
    chk("rs ch3 y", $signed(bus0.out_y), 0);
    step("rs ch2", 1'b1, 2, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
    chk("rs ch2 y", $signed(bus0.out_y), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
